// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// ------------
// VGA raster timing generator. With the default parameters it produces
// 640x480 @ 60 Hz timing from a 25 MHz pixel clock.
//
// A free-running pair of counters (h_cnt, v_cnt) walks the raster. On every
// enabled clock edge the decode of the current counter position is
// registered into the outputs, and then the counters advance. The outputs
// therefore trail the counters by one clock. Every output describes the same
// pixel in the same cycle.
//
// Ports:
//   clock_in     in   1   pixel clock
//   reset        in   1   asynchronous, active-high reset
//   enable       in   1   advance the raster; when low, everything holds
//   hsync        out  1   horizontal sync, active level = SYNC_POL
//   vsync        out  1   vertical sync, active level = SYNC_POL
//   video_on     out  1   current pixel lies inside the visible area
//   pixel_x      out  10  horizontal position, 0..H_TOTAL-1
//   pixel_y      out  10  vertical position, 0..V_TOTAL-1
//   line_start   out  1   one-cycle pulse at pixel_x == 0
//   frame_start  out  1   one-cycle pulse at pixel_x == 0 and pixel_y == 0
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 10-bit copies of the decode boundaries. The comparisons then stay at
  // counter width.
  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Decode of the current counter position.
  logic h_visible, v_visible, h_in_sync, v_in_sync;

  always_comb begin
    h_visible = (h_cnt_q < H_ACT_END);
    v_visible = (v_cnt_q < V_ACT_END);
    h_in_sync = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    v_in_sync = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  end

  always_comb begin
    // While the raster is held, the counters and level outputs keep their
    // values. The strobes default to 0 so that a pulse lasts only one cycle.
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (enable) begin
      pixel_x_d     = h_cnt_q;
      pixel_y_d     = v_cnt_q;
      video_on_d    = h_visible && v_visible;
      hsync_d       = h_in_sync ? SYNC_POL : ~SYNC_POL;
      vsync_d       = v_in_sync ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (h_cnt_q == 10'd0);
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

      // v_cnt only steps when h_cnt wraps. The equality test against
      // TOTAL-1 keeps both counters inside their ranges.
      if (h_cnt_q == H_MAX) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_MAX) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen.
// Instance "a" uses the default 640x480 timing and checks the reset values,
// the first line and an enable hold. A full 640x480 frame is too long for
// this bench, so instance "b" uses a small raster with active-high syncs.
// Instance "b" checks whole frames, the wrap, strobe suppression and a
// mid-frame asynchronous reset.
//
// Small raster for instance "b":
//   H: 16 active + 2 front porch + 4 sync + 3 back porch = 25 pixels
//   V:  6 active + 2 front porch + 2 sync + 2 back porch = 12 lines
//   One frame is 300 cycles.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_a, en_a, rst_b, en_b;
  logic       hs_a, vs_a, vid_a, ls_a, fs_a;
  logic [9:0] px_a, py_a;
  logic       hs_b, vs_b, vid_b, ls_b, fs_b;
  logic [9:0] px_b, py_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clock_in(clk), .reset(rst_a), .enable(en_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vid_a),
    .pixel_x(px_a), .pixel_y(py_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1)
  ) dut_b (
    .clock_in(clk), .reset(rst_b), .enable(en_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vid_b),
    .pixel_x(px_b), .pixel_y(py_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-24s observed=%0d expected=%0d ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge. Sampling and driving then both
  // happen 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad, hs_low, vid_cnt, hs_first, hs_last;
    int fs_edges[$];
    int vs_cnt, vs_first_x, vs_first_y, hs_b_cnt, ls_cnt, max_y, wraps;
    logic [9:0] prev_x, prev_y;
    logic       s_hs, s_vs, s_vid;
    logic [9:0] s_px, s_py;
    int guard;

    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;
    repeat (3) tick();

    // Reset values. Enable is high while reset is held, and reset wins.
    chk("a_rst_hsync", hs_a, 1);
    chk("a_rst_vsync", vs_a, 1);
    chk("a_rst_video_on", vid_a, 0);
    chk("a_rst_pixel_x", px_a, 0);
    chk("a_rst_pixel_y", py_a, 0);
    chk("a_rst_line_start", ls_a, 0);
    chk("a_rst_frame_start", fs_a, 0);
    chk("b_rst_hsync", hs_b, 0);
    chk("b_rst_vsync", vs_b, 0);

    // First line of the default raster.
    rst_a = 1'b0;
    bad = 0; hs_low = 0; vid_cnt = 0; hs_first = -1; hs_last = -1;
    for (int e = 1; e <= 800; e++) begin
      tick();
      if (e == 1) begin
        chk("a_e1_frame_start", fs_a, 1);
        chk("a_e1_line_start", ls_a, 1);
        chk("a_e1_video_on", vid_a, 1);
        chk("a_e1_pixel_x", px_a, 0);
      end
      if (px_a !== 10'(e - 1) || py_a !== 10'd0 || vs_a !== 1'b1) bad++;
      if (vid_a !== (e <= 640)) bad++;
      if (e > 1 && (ls_a !== 1'b0 || fs_a !== 1'b0)) bad++;
      if (vid_a === 1'b1) vid_cnt++;
      if (hs_a === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = e;
        hs_last = e;
      end
    end
    chk("a_line0_mismatches", bad, 0);
    chk("a_line0_video_cycles", vid_cnt, 640);
    chk("a_hsync_low_cycles", hs_low, 96);
    chk("a_hsync_first_edge", hs_first, 657);
    chk("a_hsync_last_edge", hs_last, 752);
    tick();
    chk("a_e801_line_start", ls_a, 1);
    chk("a_e801_frame_start", fs_a, 0);
    chk("a_e801_pixel_x", px_a, 0);
    chk("a_e801_pixel_y", py_a, 1);

    // Enable hold at pixel_x = 100.
    repeat (100) tick();
    chk("a_pre_hold_pixel_x", px_a, 100);
    en_a = 1'b0;
    s_hs = hs_a; s_vs = vs_a; s_vid = vid_a; s_px = px_a; s_py = py_a;
    bad = 0;
    repeat (50) begin
      tick();
      if (hs_a !== s_hs || vs_a !== s_vs || vid_a !== s_vid ||
          px_a !== s_px || py_a !== s_py || ls_a !== 1'b0 || fs_a !== 1'b0) bad++;
    end
    chk("a_hold_mismatches", bad, 0);
    en_a = 1'b1;
    tick();
    chk("a_resume_pixel_x", px_a, 101);
    chk("a_resume_pixel_y", py_a, 1);

    // Two full frames of the small raster, plus the first edge of a third.
    rst_b = 1'b0;
    bad = 0; vid_cnt = 0; vs_cnt = 0; vs_first_x = -1; vs_first_y = -1;
    hs_b_cnt = 0; ls_cnt = 0; max_y = 0; wraps = 0;
    prev_x = 10'd0; prev_y = 10'd0;
    for (int e = 1; e <= 601; e++) begin
      int idx, ex, ey;
      tick();
      idx = e - 1;
      ex = idx % 25;
      ey = (idx / 25) % 12;
      if (px_b !== 10'(ex) || py_b !== 10'(ey)) bad++;
      if (vid_b !== (ex < 16 && ey < 6)) bad++;
      if (hs_b !== (ex >= 18 && ex < 22)) bad++;
      if (vs_b !== (ey >= 8 && ey < 10)) bad++;
      if (ls_b !== (ex == 0) || fs_b !== (ex == 0 && ey == 0)) bad++;
      if (fs_b === 1'b1) fs_edges.push_back(e);
      if (e <= 300) begin
        if (vid_b === 1'b1) vid_cnt++;
        if (hs_b === 1'b1) hs_b_cnt++;
        if (ls_b === 1'b1) ls_cnt++;
        if (vs_b === 1'b1) begin
          if (vs_cnt == 0) begin vs_first_x = int'(px_b); vs_first_y = int'(py_b); end
          vs_cnt++;
        end
      end
      if (int'(py_b) > max_y) max_y = int'(py_b);
      if (e > 1 && prev_x == 10'd24 && prev_y == 10'd11) begin
        wraps++;
        if (px_b !== 10'd0 || py_b !== 10'd0 || fs_b !== 1'b1) bad++;
      end
      prev_x = px_b; prev_y = py_b;
    end
    chk("b_frame_mismatches", bad, 0);
    chk("b_frame_start_count", fs_edges.size(), 3);
    if (fs_edges.size() == 3) begin
      chk("b_frame_period_1", fs_edges[1] - fs_edges[0], 300);
      chk("b_frame_period_2", fs_edges[2] - fs_edges[1], 300);
    end
    chk("b_video_cycles_frame", vid_cnt, 96);
    chk("b_hsync_active_frame", hs_b_cnt, 48);
    chk("b_line_starts_frame", ls_cnt, 12);
    chk("b_vsync_active_cycles", vs_cnt, 50);
    chk("b_vsync_first_x", vs_first_x, 0);
    chk("b_vsync_first_y", vs_first_y, 8);
    chk("b_max_pixel_y", max_y, 11);
    chk("b_wraps_seen", wraps, 2);

    // Drop enable while the strobes are high. The strobes must clear
    // while the position holds.
    chk("b_pre_drop_frame_start", fs_b, 1);
    en_b = 1'b0;
    tick();
    chk("b_drop_frame_start", fs_b, 0);
    chk("b_drop_line_start", ls_b, 0);
    chk("b_drop_pixel_x", px_b, 0);
    chk("b_drop_video_on", vid_b, 1);
    repeat (3) tick();
    en_b = 1'b1;
    tick();
    chk("b_resume_pixel_x", px_b, 1);
    chk("b_resume_line_start", ls_b, 0);

    // Mid-frame asynchronous reset on line 4.
    guard = 0;
    while (py_b !== 10'd4 && guard < 400) begin
      tick();
      guard++;
    end
    chk("b_reached_line4", py_b, 4);
    #2;
    rst_b = 1'b1;
    #1;  // 4 ns after the edge: no clock edge has occurred yet
    chk("b_async_rst_pixel_y", py_b, 0);
    chk("b_async_rst_pixel_x", px_b, 0);
    chk("b_async_rst_hsync", hs_b, 0);
    chk("b_async_rst_video_on", vid_b, 0);
    tick();
    tick();
    rst_b = 1'b0;
    tick();
    chk("b_restart_frame_start", fs_b, 1);
    chk("b_restart_line_start", ls_b, 1);
    chk("b_restart_pixel_x", px_b, 0);
    chk("b_restart_pixel_y", py_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA raster timing for the tic-tac-toe display pipeline. It runs on the 25 MHz pixel clock produced by the pixel clock divider. It drives the board's HSYNC/VSYNC pins and supplies pixel coordinates, a video-active flag and line/frame strobes to the board renderer. All outputs are registered and mutually aligned.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: horizontal sync width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vertical sync width, in lines
- V_BP, 33: vertical back porch, in lines
- SYNC_POL, 0: active level of hsync/vsync (0 = active-low)

Ports:
- clock_in  in  1  25 MHz pixel clock from the divider
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  advance the raster; when low, the counters and all outputs hold
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  current pixel is inside the active area
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when pixel_x = 0
- frame_start  out  1  one-cycle pulse when pixel_x = 0 and pixel_y = 0

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on the h_cnt wrap, counts 0..V_TOTAL-1, and wraps to 0 when both counters are at their maximum.
- Each enabled edge registers the decode of the current (h_cnt, v_cnt) into the outputs, then advances the counters:
  - pixel_x = h_cnt, pixel_y = v_cnt
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync is active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync is active iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole of each such line
  - line_start = (h_cnt == 0); frame_start = (h_cnt == 0 && v_cnt == 0)
- Active level of the syncs = SYNC_POL; inactive level = !SYNC_POL.
- Consumers gate colour with video_on. pixel_x/pixel_y are not zeroed during blanking.
- enable low:
  - counters freeze and outputs hold their last values
  - line_start and frame_start are forced to 0 while enable is low, so a strobe never stretches
- Counters are 10 bits wide. The wrap compare is equality with TOTAL-1; no count ever reaches 1024.

## Timing
- Reset (asynchronous, immediate):
  - h_cnt = 0, v_cnt = 0
  - hsync = vsync = !SYNC_POL (inactive)
  - video_on = 0, pixel_x = 0, pixel_y = 0
  - line_start = 0, frame_start = 0
- Latency: outputs lag the counters by exactly one clock. All outputs describe the same pixel in the same cycle.
- Enabled edge n after reset release (n = 1, 2, …) presents pixel index n-1. Edge 1 therefore gives pixel_x = 0, pixel_y = 0, video_on = 1, line_start = 1, frame_start = 1.
- Periods:
  - line_start period = 800 enabled cycles
  - frame_start period = 420000 enabled cycles
  - hsync active for 96 consecutive cycles per line
  - vsync active for 1600 consecutive cycles per frame
- Reset asserted mid-frame: outputs go to reset values immediately. After release, the raster restarts at (0,0) with no partial-frame strobes.
- reset dominates enable.

## Test plan
- Reset values: hold reset, enable = 1 -> hsync = vsync = 1, video_on = 0, pixel_x = pixel_y = 0, strobes = 0.
- First line: release reset, enable = 1 -> edges 1..640 give video_on = 1 with pixel_x = 0..639; hsync is low on edges 657..752; edge 801 gives line_start = 1, pixel_x = 0, pixel_y = 1.
- Full frame: run 2 frames -> successive frame_start pulses are 420000 cycles apart; exactly 307200 video_on cycles per frame; vsync is low for 1600 cycles starting at pixel_y = 490, pixel_x = 0.
- Wrap: at pixel_x = 799, pixel_y = 524 -> next output is (0,0) with frame_start = 1; pixel_y never shows 525.
- Enable hold: drop enable for 50 cycles at pixel_x = 100 -> all outputs frozen, no strobes; on resume the next output is pixel_x = 101.
- Mid-frame reset: assert reset at pixel_y = 200 -> outputs go to reset values without waiting for a clock edge; after release, edge 1 gives frame_start = 1 at (0,0).
